rand_stim_checker: RTL and testbench
====================================

RAND_STIM_CHECKER -- requirements
Module: rand_stim_checker

Interface
REQ-001 SHALL have parameter VEC_W, default 16, width of the vector count and error counters.
REQ-002 SHALL have parameter LFSR_POLY, default 8'hB8, Galois feedback taps for x^8+x^6+x^5+x^4+1.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a test run; honoured only in IDLE or DONE.
REQ-006 SHALL have port num_vectors  input  VEC_W  number of stimulus vectors per run; sampled on start.
REQ-007 SHALL have port seed  input  8  LFSR seed; sampled on start; 0 is replaced by 8'h01.
REQ-008 SHALL have port dut_rst  output  1  reset driven to the circuit under test.
REQ-009 SHALL have ports a_out, b_out  output  1 each  stimulus bits A and B driven to the circuit under test.
REQ-010 SHALL have port q_in  input  1  registered output Q returned from the circuit under test.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on entry to DONE.
REQ-013 SHALL have port pass  output  1  high in DONE when err_count is 0.
REQ-014 SHALL have port err_count  output  VEC_W  mismatches in the current or last run; saturates at all-ones.
REQ-015 SHALL have port first_err_idx  output  VEC_W  index of the first mismatching vector; all-ones if none.

Function
REQ-016 SHALL implement FSM states IDLE, DUT_RST, DRIVE, DRAIN, DONE.
REQ-017 IDLE/DONE + start: SHALL load LFSR, latch num_vectors, clear err_count, set first_err_idx to all-ones, go to DUT_RST.
REQ-018 DUT_RST: dut_rst=1 for exactly 2 cycles, a_out=b_out=0; then go to DRIVE (or straight to DONE when num_vectors==0).
REQ-019 DRIVE: each cycle SHALL drive {a_out,b_out}=LFSR[1:0], advance the LFSR, and increment vector index; leave after vector num_vectors-1.
REQ-020 Expected Q for a vector SHALL be (~(A&B) & ~(A|B)) | ((A^B) ^ (A&B)), with & binding tighter than ^ and ^ tighter than |; this is 1 for every A,B.
REQ-021 Expected value and index SHALL pass through a 1-stage delay pipe; q_in in cycle n+1 SHALL be compared with the expectation for the vector driven in cycle n.
REQ-022 The compare SHALL be valid only for cycles following a DRIVE cycle; it SHALL NOT be made during DUT_RST or the first DRIVE cycle.
REQ-023 DRAIN: 1 cycle, performs the final compare, then go to DONE with a done pulse.
REQ-024 On mismatch: err_count SHALL increment (saturating); first_err_idx SHALL be written only while still all-ones.
REQ-025 start SHALL be ignored while busy; start in the same cycle as rst SHALL be ignored.
REQ-026 DONE SHALL hold its outputs until the next start; a_out=b_out=0 outside DRIVE.

Reset
REQ-027 rst SHALL force IDLE, dut_rst=1, a_out=b_out=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=all-ones, LFSR=8'h01, whether or not a run is in progress.
REQ-028 dut_rst SHALL drop to 0 in the first cycle after rst deasserts; it SHALL be 0 in IDLE except when rst is asserted.

Structure
REQ-029 The state enum, default LFSR_POLY and the seed-zero replacement constant SHALL live in package rand_stim_pkg.
REQ-030 The LFSR SHALL be the sub-module galois_lfsr8 (load, seed, enable, state).
REQ-031 The expected-Q function SHALL be a package function so testbenches reuse it.

Verification
REQ-032 rst mid-DRIVE (vector 5 of 20) -> next cycle IDLE, busy=0, err_count=0, dut_rst high while rst is held.
REQ-033 num_vectors=0, start -> 2 cycles dut_rst, then done pulse, pass=1, err_count=0.
REQ-034 seed=8'h00, num_vectors=8, correct DUT model -> sequence equals the seed 8'h01 run, pass=1, done 12 cycles after start.
REQ-035 num_vectors=100, DUT model with Q forced 0 on vector index 37 only -> err_count=1, first_err_idx=37, pass=0.
REQ-036 q_in stuck 0, num_vectors=16'hFFFF, VEC_W=16 -> err_count saturates at 16'hFFFF, first_err_idx=0.
REQ-037 start pulsed at cycle 3 of DRIVE -> ignored, run completes unchanged, exactly one done pulse.

Source files
------------

// File: rtl/rand_stim_pkg.sv
// rand_stim_pkg -- shared definitions for the random-stimulus checker.
//   state_e           : checker FSM states
//   LFSR_POLY_DEFAULT : Galois taps for x^8+x^6+x^5+x^4+1 (right-shifting form)
//   SEED_ZERO_SUB     : seed used when the requested seed is 0 (LFSR lock-up state)
//   LFSR_RESET_STATE  : LFSR contents after rst
//   expected_q()      : reference response of the circuit under test; testbenches
//                       import this so they agree with the checker by construction
package rand_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DUT_RST = 3'd1,
        ST_DRIVE   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [7:0] LFSR_POLY_DEFAULT = 8'hB8;
    localparam logic [7:0] SEED_ZERO_SUB     = 8'h01;
    localparam logic [7:0] LFSR_RESET_STATE  = 8'h01;

    // Written exactly as the circuit's equation; it reduces to constant 1 for
    // every (a, b), which is what a correct circuit under test must return.
    function automatic logic expected_q(input logic a, input logic b);
        return (~(a & b) & ~(a | b)) | ((a ^ b) ^ (a & b));
    endfunction

endpackage

// File: rtl/galois_lfsr8.sv
// galois_lfsr8 -- 8-bit right-shifting Galois LFSR.
//   clk    : clock
//   rst    : synchronous active-high reset, state -> LFSR_RESET_STATE
//   load   : load seed (takes priority over enable)
//   seed   : value loaded when load is high
//   enable : advance one step
//   state  : current LFSR contents
module galois_lfsr8
    import rand_stim_pkg::*;
#(
    parameter logic [7:0] POLY = LFSR_POLY_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       enable,
    output logic [7:0] state
);

    logic [7:0] state_q;
    logic [7:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (enable) begin
            // Shift out bit 0; when it was set, fold the taps back in.
            state_d = {1'b0, state_q[7:1]} ^ (state_q[0] ? POLY : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LFSR_RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/rand_stim_checker.sv
// rand_stim_checker -- drives pseudo-random A/B vectors into a registered
// circuit under test and checks each returned Q against expected_q().
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a run (accepted only in IDLE or DONE)
//   num_vectors, seed   : run length and LFSR seed, captured on start
//   dut_rst             : reset to the circuit under test
//   a_out, b_out        : stimulus bits (zero outside DRIVE)
//   q_in                : registered response from the circuit under test
//   busy, done, pass    : run status; done pulses once on entering DONE
//   err_count           : saturating mismatch count of current/last run
//   first_err_idx       : index of first mismatching vector, all-ones if none
module rand_stim_checker
    import rand_stim_pkg::*;
#(
    parameter int         VEC_W     = 16,
    parameter logic [7:0] LFSR_POLY = LFSR_POLY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VEC_W-1:0] num_vectors,
    input  logic [7:0]       seed,
    output logic             dut_rst,
    output logic             a_out,
    output logic             b_out,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [VEC_W-1:0] err_count,
    output logic [VEC_W-1:0] first_err_idx
);

    localparam logic [VEC_W-1:0] ALL_ONES = '1;
    localparam logic [VEC_W-1:0] ONE      = VEC_W'(1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] total_q, total_d;
    logic [VEC_W-1:0] idx_q, idx_d;
    logic [VEC_W-1:0] err_q, err_d;
    logic [VEC_W-1:0] first_q, first_d;
    logic             rst_cnt_q, rst_cnt_d;
    logic             done_q, done_d;

    // One-stage pipe holding the expectation for the vector driven last cycle.
    logic             exp_val_q;
    logic [VEC_W-1:0] exp_idx_q;
    logic             cmp_vld_q;

    logic             start_ok;
    logic             in_drive;
    logic             mismatch;
    logic [7:0]       lfsr_state;
    logic [7:0]       lfsr_seed;
    logic [5:0]       lfsr_unused;
    logic             a_bit, b_bit;

    assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign in_drive  = (state_q == ST_DRIVE);
    assign lfsr_seed = (seed == 8'h00) ? SEED_ZERO_SUB : seed;

    galois_lfsr8 #(
        .POLY (LFSR_POLY)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (start_ok),
        .seed   (lfsr_seed),
        .enable (in_drive),
        .state  (lfsr_state)
    );

    assign {lfsr_unused, a_bit, b_bit} = lfsr_state;

    assign a_out = in_drive & a_bit;
    assign b_out = in_drive & b_bit;
    assign mismatch = cmp_vld_q && (q_in != exp_val_q);

    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        idx_d     = idx_q;
        err_d     = err_q;
        first_d   = first_q;
        rst_cnt_d = rst_cnt_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    total_d   = num_vectors;
                    idx_d     = '0;
                    err_d     = '0;
                    first_d   = ALL_ONES;
                    rst_cnt_d = 1'b0;
                    state_d   = ST_DUT_RST;
                end
            end
            ST_DUT_RST: begin
                // Second DUT_RST cycle decides; a zero-length run skips DRIVE.
                if (rst_cnt_q) begin
                    if (total_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end else begin
                    rst_cnt_d = 1'b1;
                end
            end
            ST_DRIVE: begin
                idx_d = idx_q + ONE;
                if (idx_q == total_q - ONE) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Compares only happen in DRIVE/DRAIN, never alongside a start.
        if (mismatch) begin
            if (err_q != ALL_ONES) begin
                err_d = err_q + ONE;
            end
            if (first_q == ALL_ONES) begin
                first_d = exp_idx_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            total_q   <= '0;
            idx_q     <= '0;
            err_q     <= '0;
            first_q   <= ALL_ONES;
            rst_cnt_q <= 1'b0;
            done_q    <= 1'b0;
            exp_val_q <= 1'b0;
            exp_idx_q <= '0;
            cmp_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            first_q   <= first_d;
            rst_cnt_q <= rst_cnt_d;
            done_q    <= done_d;
            exp_val_q <= expected_q(a_out, b_out);
            exp_idx_q <= idx_q;
            cmp_vld_q <= in_drive;
        end
    end

    // rst is passed straight through so the circuit under test is held in
    // reset for exactly as long as the checker is.
    assign dut_rst       = rst || (state_q == ST_DUT_RST);
    assign busy          = !(state_q == ST_IDLE || state_q == ST_DONE);
    assign done          = done_q;
    assign pass          = (state_q == ST_DONE) && (err_q == '0);
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_rand_stim_checker.sv
// tb_rand_stim_checker -- directed self-checking bench for rand_stim_checker.
// A behavioural circuit under test (registered Q with optional fault
// injection) closes the loop; a scoreboard holds the expected stimulus pairs
// and per-run results.
module tb_rand_stim_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_vectors = '0;
    logic [7:0]  seed = '0;
    logic        dut_rst, a_out, b_out, busy, done, pass;
    logic        q_in = 1'b0;
    logic [15:0] err_count, first_err_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  stim_q[$];
    logic [31:0] res_q[$];

    int fault_idx = -1;
    bit stuck0    = 1'b0;
    int vcnt      = 0;

    always #5 clk = ~clk;

    rand_stim_checker #(.VEC_W(16), .LFSR_POLY(8'hB8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_vectors   (num_vectors),
        .seed          (seed),
        .dut_rst       (dut_rst),
        .a_out         (a_out),
        .b_out         (b_out),
        .q_in          (q_in),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    // Circuit under test: Q registers the equation; faults force Q to 0.
    always @(posedge clk) begin
        if (dut_rst) begin
            vcnt <= 0;
            q_in <= 1'b0;
        end else begin
            if (stuck0 || (busy && vcnt == fault_idx))
                q_in <= 1'b0;
            else
                q_in <= (~(a_out & b_out) & ~(a_out | b_out)) | ((a_out ^ b_out) ^ (a_out & b_out));
            if (busy) vcnt <= vcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete run; restart_at >= 1 pulses a stray start after that many
    // DRIVE vectors, carrying different num_vectors/seed values.
    task automatic run_test(input logic [15:0] nv, input logic [7:0] sd, input int f_idx,
                            input bit st0, input int restart_at,
                            input logic [15:0] exp_err, input logic [15:0] exp_first);
        logic [7:0]  s;
        logic [1:0]  e;
        logic [31:0] r;
        int          cyc, drv, rcyc, ndone, lat;
        bit          exp_pass;
        s = (sd == 8'h00) ? 8'h01 : sd;
        for (int k = 0; k < int'(nv); k++) begin
            stim_q.push_back(s[1:0]);
            s = {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
        end
        res_q.push_back({exp_err, exp_first});
        exp_pass  = (exp_err == 16'h0000);
        lat       = (nv == 16'h0000) ? 3 : int'(nv) + 4;
        fault_idx = f_idx;
        stuck0    = st0;
        @(negedge clk);
        num_vectors = nv;
        seed        = sd;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        num_vectors = ~nv;
        seed        = ~sd;
        cyc = 1; drv = 0; rcyc = 0; ndone = 0;
        while (ndone == 0 && cyc <= lat + 5) begin
            start = 1'b0;
            if (dut_rst) begin
                rcyc++;
                check("ab_in_dut_rst", {30'd0, a_out, b_out}, 32'd0);
            end else if (busy && drv < int'(nv)) begin
                e = stim_q.pop_front();
                check("stimulus", {30'd0, a_out, b_out}, {30'd0, e});
                drv++;
                if (drv == restart_at) begin
                    check("busy_at_stray_start", {31'd0, busy}, 32'd1);
                    start = 1'b1;
                end
            end
            if (done) begin
                ndone++;
                r = res_q.pop_front();
                check("done_latency", cyc, lat);
                check("err_count", {16'd0, err_count}, {16'd0, r[31:16]});
                check("first_err_idx", {16'd0, first_err_idx}, {16'd0, r[15:0]});
                check("pass", {31'd0, pass}, {31'd0, exp_pass});
                check("busy_in_done", {31'd0, busy}, 32'd0);
            end
            if (ndone == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", ndone, 1);
        check("dut_rst_cycles", rcyc, 2);
        check("vectors_driven", drv, int'(nv));
        repeat (3) begin
            @(negedge clk);
            check("done_single_pulse", {31'd0, done}, 32'd0);
            check("pass_held", {31'd0, pass}, {31'd0, exp_pass});
            check("err_held", {16'd0, err_count}, {16'd0, exp_err});
            check("ab_idle", {30'd0, a_out, b_out}, 32'd0);
        end
        stim_q.delete();
        res_q.delete();
        fault_idx = -1;
        stuck0    = 1'b0;
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(negedge clk);
        check("rst_dut_rst", {31'd0, dut_rst}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_err", {16'd0, err_count}, 32'd0);
        check("rst_first", {16'd0, first_err_idx}, 32'h0000FFFF);
        check("rst_ab", {30'd0, a_out, b_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_dut_rst_low", {31'd0, dut_rst}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Clean runs; seed 0 must reproduce the seed 1 sequence
        run_test(16'd8, 8'h01, -1, 1'b0, 0, 16'h0000, 16'hFFFF);
        run_test(16'd8, 8'h00, -1, 1'b0, 0, 16'h0000, 16'hFFFF);
        // Zero-length run
        run_test(16'd0, 8'h42, -1, 1'b0, 0, 16'h0000, 16'hFFFF);
        // Single fault on vector 37
        run_test(16'd100, 8'hA5, 37, 1'b0, 0, 16'h0001, 16'd37);
        // Stray start during DRIVE must be ignored
        run_test(16'd20, 8'h3C, -1, 1'b0, 3, 16'h0000, 16'hFFFF);

        // Reset during vector 5 of a 20-vector run that is accumulating errors
        stuck0 = 1'b1;
        @(negedge clk);
        num_vectors = 16'd20;
        seed        = 8'h77;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        check("abort_err_nonzero", {31'd0, (err_count != 16'd0)}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_err", {16'd0, err_count}, 32'd0);
        check("abort_first", {16'd0, first_err_idx}, 32'h0000FFFF);
        check("abort_dut_rst", {31'd0, dut_rst}, 32'd1);
        check("abort_ab", {30'd0, a_out, b_out}, 32'd0);
        @(negedge clk);
        check("abort_dut_rst_held", {31'd0, dut_rst}, 32'd1);
        rst    = 1'b0;
        stuck0 = 1'b0;
        @(negedge clk);
        check("abort_dut_rst_low", {31'd0, dut_rst}, 32'd0);

        // start coincident with rst is ignored
        rst         = 1'b1;
        start       = 1'b1;
        num_vectors = 16'd5;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("start_with_rst_busy", {31'd0, busy}, 32'd0);
        check("start_with_rst_dut_rst", {31'd0, dut_rst}, 32'd0);

        // q_in stuck at 0 over a full-length run: counter saturates
        run_test(16'hFFFF, 8'h5A, -1, 1'b1, 0, 16'hFFFF, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
